life_grid_engine: RTL and testbench



---
 rtl/life_pkg.sv | 38 +++
 rtl/life_grid_engine_if.sv | 16 +
 rtl/life_display_fmt.sv | 77 +++++++
 rtl/life_grid_engine.sv | 199 +++++++++++++++++++
 tb/tb_life_grid_engine.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/life_pkg.sv
// Shared constants, state encoding and neighbour offset table for the Game-of-Life engine.
package life_pkg;
  localparam logic [1:0] CMD_SEED  = 2'd0;
  localparam logic [1:0] CMD_STEP  = 2'd1;
  localparam logic [1:0] CMD_CLEAR = 2'd2;
  localparam logic [1:0] CMD_RUN   = 2'd3;

  localparam logic [7:0] ANSI_ESC  = 8'h1B;
  localparam logic [7:0] ANSI_LBR  = 8'h5B;
  localparam logic [7:0] ANSI_SEMI = 8'h3B;
  localparam logic [7:0] ANSI_HOME = 8'h48;
  localparam logic [7:0] CHR_CR    = 8'h0D;
  localparam logic [7:0] CHR_LF    = 8'h0A;

  localparam int NEIGH_COUNT = 8;

  typedef enum logic [2:0] {S_IDLE, S_SEED, S_CLEAR, S_EVAL, S_COPY, S_DISP} state_e;

  typedef struct packed {
    logic [1:0] code;
    logic       wrap;
  } life_cmd_t;

  // Returns {dx, dy}; each 2-bit field is 00 = 0, 01 = +1, 11 = -1.
  function automatic logic [3:0] neigh_off(input logic [3:0] k);
    case (k)
      4'd0:    neigh_off = 4'b11_01;
      4'd1:    neigh_off = 4'b00_01;
      4'd2:    neigh_off = 4'b01_01;
      4'd3:    neigh_off = 4'b11_00;
      4'd4:    neigh_off = 4'b01_00;
      4'd5:    neigh_off = 4'b11_11;
      4'd6:    neigh_off = 4'b00_11;
      4'd7:    neigh_off = 4'b01_11;
      default: neigh_off = 4'b00_00;
    endcase
  endfunction
endpackage

// File: rtl/life_grid_engine_if.sv
// Command and display-stream handshake bundle; the engine is the slave side.
interface life_grid_engine_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_code;
  logic       wrap_mode;
  logic       seed_bit;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;

  modport master (output cmd_valid, cmd_code, wrap_mode, seed_bit, out_ready,
                  input  cmd_ready, out_data, out_valid);
  modport slave  (input  cmd_valid, cmd_code, wrap_mode, seed_bit, out_ready,
                  output cmd_ready, out_data, out_valid);
endinterface

// File: rtl/life_display_fmt.sv
// Display byte sequencer: ANSI cursor-home header, then H rows of W cell bytes each ended by CR LF.
module life_display_fmt
  import life_pkg::*;
#(
  parameter int         LOG_W     = 4,
  parameter int         LOG_H     = 3,
  parameter logic [7:0] LIVE_CHAR = 8'h4F,
  parameter logic [7:0] DEAD_CHAR = 8'h20
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  output logic [LOG_W+LOG_H-1:0] rd_addr,
  input  logic                   rd_bit,
  output logic [7:0]             out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   done
);
  localparam int W  = 1 << LOG_W;
  localparam int CW = LOG_W + 1;

  logic             active, in_hdr, xfer, row_end;
  logic [1:0]       hidx;
  logic [CW-1:0]    col;
  logic [LOG_H-1:0] row;

  assign xfer      = active && out_ready;
  assign row_end   = (col == CW'(W + 1));
  assign done      = xfer && !in_hdr && row_end && (&row);
  assign out_valid = active;
  assign rd_addr   = {row, col[LOG_W-1:0]};

  // Byte is a pure function of the position registers, so it holds while stalled.
  always_comb begin
    out_data = 8'h00;
    if (active) begin
      if (in_hdr) begin
        case (hidx)
          2'd0:    out_data = ANSI_ESC;
          2'd1:    out_data = ANSI_LBR;
          2'd2:    out_data = ANSI_SEMI;
          default: out_data = ANSI_HOME;
        endcase
      end else if (!col[LOG_W]) out_data = rd_bit ? LIVE_CHAR : DEAD_CHAR;
      else if (!col[0])         out_data = CHR_CR;
      else                      out_data = CHR_LF;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active <= 1'b0;
      in_hdr <= 1'b0;
      hidx   <= '0;
      col    <= '0;
      row    <= '0;
    end else if (start) begin
      active <= 1'b1;
      in_hdr <= 1'b1;
      hidx   <= '0;
      col    <= '0;
      row    <= '0;
    end else if (xfer) begin
      if (in_hdr) begin
        hidx <= hidx + 2'd1;
        if (hidx == 2'd3) in_hdr <= 1'b0;
      end else if (row_end) begin
        col <= '0;
        row <= row + LOG_H'(1);
        if (&row) active <= 1'b0;
      end else begin
        col <= col + CW'(1);
      end
    end
  end
endmodule

// File: rtl/life_grid_engine.sv
// Game-of-Life engine: board storage, serial 9-cycle-per-cell evaluator, copy-back and display.
// Optional LIFE_AUTORUN_EN adds a self-timed STEP issued every TICK_CYCLES idle cycles while running.
module life_grid_engine
  import life_pkg::*;
#(
`ifdef LIFE_AUTORUN_EN
  parameter int         TICK_CYCLES = 4800000,
`endif
  parameter int         LOG_W     = 4,
  parameter int         LOG_H     = 3,
  parameter logic [7:0] LIVE_CHAR = 8'h4F,
  parameter logic [7:0] DEAD_CHAR = 8'h20
) (
  input  logic                   clk,
  input  logic                   rst_n,
  life_grid_engine_if.slave      bus,
  output logic                   busy,
  output logic [LOG_W+LOG_H:0]   population,
  output logic [15:0]            gen_count,
  output logic                   stable
);
  localparam int N  = 1 << (LOG_W + LOG_H);
  localparam int AW = LOG_W + LOG_H;
  localparam int PW = AW + 1;

  state_e           state, state_nxt;
  logic [N-1:0]     board, nxt;
  logic [AW-1:0]    idx, rd_addr;
  logic [3:0]       ph, ncnt, off;
  logic [PW-1:0]    pop_acc;
  logic             change, wrap, acc, go, last_idx, fmt_start, fmt_done;
  logic [LOG_W-1:0] cx, nx;
  logic [LOG_H-1:0] cy, ny;
  logic             offx, offy, nbit, cur, newv;
  life_cmd_t        cmd;

  assign acc           = bus.cmd_valid && bus.cmd_ready;
  assign bus.cmd_ready = (state == S_IDLE);
  assign busy          = (state != S_IDLE);
  assign last_idx      = (idx == AW'(N - 1));

`ifdef LIFE_AUTORUN_EN
  localparam int TW = $clog2(TICK_CYCLES + 1);
  logic          run, tick;
  logic [TW-1:0] tcnt;

  // An external command in the tick cycle wins and the tick is dropped.
  assign tick = run && (state == S_IDLE) && (tcnt == TW'(TICK_CYCLES - 1)) && !acc;
  assign go   = acc || tick;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run  <= 1'b0;
      tcnt <= '0;
    end else begin
      if (acc && bus.cmd_code == CMD_RUN) run <= !run;
      if (acc || tick || !run)  tcnt <= '0;
      else if (state == S_IDLE) tcnt <= tcnt + TW'(1);
    end
  end

  always_comb begin
    cmd.code = acc ? bus.cmd_code : CMD_STEP;
    cmd.wrap = bus.wrap_mode;
  end
`else
  assign go = acc;
  always_comb begin
    cmd.code = bus.cmd_code;
    cmd.wrap = bus.wrap_mode;
  end
`endif

  // Neighbour address for the current accumulate phase; power-of-two sizes make wrap free.
  always_comb begin
    cx   = idx[LOG_W-1:0];
    cy   = idx[AW-1:LOG_W];
    off  = neigh_off(ph);
    nx   = cx;
    ny   = cy;
    offx = 1'b0;
    offy = 1'b0;
    if (off[3:2] == 2'b01)      begin nx = cx + LOG_W'(1); offx = &cx;  end
    else if (off[3:2] == 2'b11) begin nx = cx - LOG_W'(1); offx = ~|cx; end
    if (off[1:0] == 2'b01)      begin ny = cy + LOG_H'(1); offy = &cy;  end
    else if (off[1:0] == 2'b11) begin ny = cy - LOG_H'(1); offy = ~|cy; end
    nbit = board[{ny, nx}] && (wrap || !(offx || offy));
    cur  = board[idx];
    newv = (cur && ncnt == 4'd2) || (ncnt == 4'd3);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:
        if (go) begin
          case (cmd.code)
            CMD_SEED:  state_nxt = S_SEED;
            CMD_STEP:  state_nxt = S_EVAL;
            CMD_CLEAR: state_nxt = S_CLEAR;
            default:   state_nxt = S_IDLE;
          endcase
        end
      S_SEED:  if (last_idx) state_nxt = S_DISP;
      S_CLEAR: state_nxt = S_DISP;
      S_EVAL:  if (ph == 4'(NEIGH_COUNT) && last_idx) state_nxt = S_COPY;
      S_COPY:  if (last_idx) state_nxt = S_DISP;
      S_DISP:  if (fmt_done) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  assign fmt_start = (state != S_DISP) && (state_nxt == S_DISP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      board      <= '0;
      nxt        <= '0;
      idx        <= '0;
      ph         <= '0;
      ncnt       <= '0;
      change     <= 1'b0;
      wrap       <= 1'b0;
      pop_acc    <= '0;
      population <= '0;
      gen_count  <= '0;
      stable     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          idx     <= '0;
          ph      <= '0;
          ncnt    <= '0;
          change  <= 1'b0;
          pop_acc <= '0;
          if (go) wrap <= cmd.wrap;
        end
        S_SEED: begin
          board[idx] <= bus.seed_bit;
          pop_acc    <= pop_acc + PW'(bus.seed_bit);
          idx        <= idx + AW'(1);
          if (last_idx) begin
            population <= pop_acc + PW'(bus.seed_bit);
            gen_count  <= '0;
            stable     <= 1'b0;
          end
        end
        S_CLEAR: begin
          board      <= '0;
          population <= '0;
          gen_count  <= '0;
          stable     <= 1'b0;
        end
        S_EVAL: begin
          if (ph == 4'(NEIGH_COUNT)) begin
            nxt[idx] <= newv;
            if (newv != cur) change <= 1'b1;
            ncnt <= '0;
            ph   <= '0;
            idx  <= idx + AW'(1);
          end else begin
            ncnt <= ncnt + {3'b000, nbit};
            ph   <= ph + 4'd1;
          end
        end
        S_COPY: begin
          board[idx] <= nxt[idx];
          pop_acc    <= pop_acc + PW'(nxt[idx]);
          idx        <= idx + AW'(1);
          if (last_idx) begin
            population <= pop_acc + PW'(nxt[idx]);
            gen_count  <= gen_count + 16'd1;
            stable     <= !change;
          end
        end
        default: ;
      endcase
    end
  end

  life_display_fmt #(
    .LOG_W(LOG_W), .LOG_H(LOG_H), .LIVE_CHAR(LIVE_CHAR), .DEAD_CHAR(DEAD_CHAR)
  ) u_fmt (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (fmt_start),
    .rd_addr   (rd_addr),
    .rd_bit    (board[rd_addr]),
    .out_data  (bus.out_data),
    .out_valid (bus.out_valid),
    .out_ready (bus.out_ready),
    .done      (fmt_done)
  );
endmodule

// File: tb/tb_life_grid_engine.sv
// Directed bench for life_grid_engine: reference Life model plus a byte scoreboard on the display stream.
module tb_life_grid_engine;
  import life_pkg::*;

  localparam int LOG_W = 4, LOG_H = 3;
  localparam int W = 16, H = 8, N = 128;
  localparam int NB = 4 + H * (W + 2);

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        busy, stable;
  logic [7:0]  population;
  logic [15:0] gen_count;

  life_grid_engine_if bus();

  life_grid_engine #(
`ifdef LIFE_AUTORUN_EN
    .TICK_CYCLES(2000),
`endif
    .LOG_W(LOG_W), .LOG_H(LOG_H), .LIVE_CHAR(8'h4F), .DEAD_CHAR(8'h20)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .busy(busy),
    .population(population), .gen_count(gen_count), .stable(stable)
  );

  always #5 clk = ~clk;

  int         n_pass = 0, n_fail = 0, n_tot = 0, nbytes = 0;
  logic       bp_en = 1'b0;
  int         bpc = 0;
  logic [7:0] exp_q[$];
  logic [N-1:0] mb;
  int         m_gen;
  logic       m_stable;

  // Consumer ready: held high, or toggled every 3 cycles for the backpressure test.
  always @(posedge clk) begin
    #1;
    if (bp_en) begin
      bpc++;
      if (bpc == 3) begin bpc = 0; bus.out_ready = !bus.out_ready; end
    end else begin
      bus.out_ready = 1'b1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tot++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [N-1:0] life_next(input logic [N-1:0] b, input logic wr);
    logic [N-1:0] r;
    int n, xx, yy;
    r = '0;
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++) begin
        n = 0;
        for (int dy = -1; dy <= 1; dy++)
          for (int dx = -1; dx <= 1; dx++) begin
            if (dx == 0 && dy == 0) continue;
            xx = x + dx;
            yy = y + dy;
            if (wr) begin xx = (xx + W) % W; yy = (yy + H) % H; end
            else if (xx < 0 || xx >= W || yy < 0 || yy >= H) continue;
            n += int'(b[yy*W + xx]);
          end
        r[y*W + x] = (n == 3) || (b[y*W + x] && n == 2);
      end
    return r;
  endfunction

  task automatic push_stream(input logic [N-1:0] b);
    exp_q.push_back(8'h1B); exp_q.push_back(8'h5B);
    exp_q.push_back(8'h3B); exp_q.push_back(8'h48);
    for (int y = 0; y < H; y++) begin
      for (int x = 0; x < W; x++) exp_q.push_back(b[y*W + x] ? 8'h4F : 8'h20);
      exp_q.push_back(8'h0D); exp_q.push_back(8'h0A);
    end
  endtask

  // Pops one expected byte per transfer; also checks that stalled bytes stay put.
  task automatic stream_mon();
    logic [7:0]  held;
    logic        stall;
    logic [31:0] e;
    stall = 1'b0;
    held  = '0;
    forever begin
      @(negedge clk);
      if (stall) begin
        chk("stall_valid", bus.out_valid, 1);
        chk("stall_data", bus.out_data, held);
      end
      stall = bus.out_valid && !bus.out_ready;
      held  = bus.out_data;
      if (bus.out_valid && bus.out_ready) begin
        nbytes++;
        e = (exp_q.size() != 0) ? {24'b0, exp_q.pop_front()} : 32'hFFFF_FFFF;
        chk("stream_byte", bus.out_data, e);
      end
    end
  endtask

  task automatic run_cmd(input logic [1:0] code, input logic wr, input logic [N-1:0] seed,
                         output int lat);
    int t;
    logic [N-1:0] nb;
    case (code)
      CMD_SEED:  begin mb = seed; m_gen = 0; m_stable = 1'b0; push_stream(mb); end
      CMD_STEP:  begin
        nb = life_next(mb, wr);
        m_stable = (nb == mb);
        mb = nb;
        m_gen = (m_gen + 1) % 65536;
        push_stream(mb);
      end
      CMD_CLEAR: begin mb = '0; m_gen = 0; m_stable = 1'b0; push_stream(mb); end
      default: ;
    endcase
    nbytes = 0;
    @(negedge clk);
    chk("cmd_ready_idle", bus.cmd_ready, 1);
    bus.cmd_valid = 1'b1; bus.cmd_code = code; bus.wrap_mode = wr;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    if (code == CMD_SEED)
      for (int i = 0; i < N; i++) begin @(negedge clk); bus.seed_bit = seed[i]; end
    t = 0;
    @(negedge clk);
    while (!bus.out_valid && busy && t < 5000) begin @(negedge clk); t++; end
    lat = t;
    while (busy && t < 20000) begin @(negedge clk); t++; end
    chk("done_in_time", busy, 0);
    chk("idle_out_valid", bus.out_valid, 0);
    chk("stream_drained", exp_q.size(), 0);
    if (code != CMD_RUN) chk("byte_count", nbytes, NB);
    chk("gen_count", gen_count, m_gen);
    chk("stable", stable, m_stable);
    if (code != CMD_SEED) chk("population", population, $countones(mb));
  endtask

  initial begin
    int lat, t, seen;
    logic [N-1:0] s, blinker, nb;
    bus.cmd_valid = 1'b0; bus.cmd_code = 2'd0; bus.wrap_mode = 1'b0; bus.seed_bit = 1'b0;
    mb = '0; m_gen = 0; m_stable = 1'b0;
    fork stream_mon(); join_none

    repeat (3) @(negedge clk);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_data", bus.out_data, 0);
    chk("rst_cmd_ready", bus.cmd_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_population", population, 0);
    chk("rst_gen_count", gen_count, 0);
    chk("rst_stable", stable, 0);
    rst_n = 1'b1;

    // Blinker on a wrapped board, including STEP-to-DISP latency
    blinker = '0;
    blinker[3*W+4] = 1'b1; blinker[3*W+5] = 1'b1; blinker[3*W+6] = 1'b1;
    run_cmd(CMD_SEED, 1'b1, blinker, lat);
    run_cmd(CMD_STEP, 1'b1, '0, lat);
    chk("step_latency", lat, 10 * N);
    chk("blinker_pop", population, 3);

    // Block still life
    s = '0;
    s[2*W+2] = 1'b1; s[2*W+3] = 1'b1; s[3*W+2] = 1'b1; s[3*W+3] = 1'b1;
    run_cmd(CMD_SEED, 1'b0, s, lat);
    run_cmd(CMD_STEP, 1'b0, '0, lat);
    chk("block_stable", stable, 1);

    // Corner cells: wrap closes a block across the edges, border kills them
    s = '0;
    s[0] = 1'b1; s[15] = 1'b1; s[7*W] = 1'b1;
    run_cmd(CMD_SEED, 1'b1, s, lat);
    run_cmd(CMD_STEP, 1'b1, '0, lat);
    chk("wrap_pop", population, 4);
    run_cmd(CMD_STEP, 1'b1, '0, lat);
    chk("wrap_stable", stable, 1);
    run_cmd(CMD_SEED, 1'b0, s, lat);
    run_cmd(CMD_STEP, 1'b0, '0, lat);
    chk("border_pop", population, 0);

    // RUN twice leaves the engine as it was, with no display
    run_cmd(CMD_RUN, 1'b0, '0, lat);
    run_cmd(CMD_RUN, 1'b0, '0, lat);

    // Display stream under backpressure
    bp_en = 1'b1;
    run_cmd(CMD_CLEAR, 1'b0, '0, lat);
    bp_en = 1'b0;
    repeat (2) @(negedge clk);

    // Reset in the middle of an evaluation
    s = '0;
    s[2*W+2] = 1'b1; s[2*W+3] = 1'b1; s[3*W+2] = 1'b1; s[3*W+3] = 1'b1;
    run_cmd(CMD_SEED, 1'b0, s, lat);
    run_cmd(CMD_STEP, 1'b0, '0, lat);
    @(negedge clk);
    bus.cmd_valid = 1'b1; bus.cmd_code = CMD_STEP; bus.wrap_mode = 1'b0;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    repeat (499) @(posedge clk);
    #2 rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_out_valid", bus.out_valid, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_population", population, 0);
    chk("midrst_gen_count", gen_count, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_cmd_ready", bus.cmd_ready, 1);
    mb = '0; m_gen = 0; m_stable = 1'b0;
    run_cmd(CMD_STEP, 1'b1, '0, lat);
    chk("post_rst_empty_stable", stable, 1);

`ifdef LIFE_AUTORUN_EN
    run_cmd(CMD_SEED, 1'b1, blinker, lat);
    @(negedge clk);
    bus.cmd_valid = 1'b1; bus.cmd_code = CMD_RUN; bus.wrap_mode = 1'b1;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      nb = life_next(mb, 1'b1);
      m_stable = (nb == mb);
      mb = nb;
      m_gen = m_gen + 1;
      push_stream(mb);
      t = 0;
      while (!busy && t < 3000) begin @(negedge clk); t++; end
      chk("tick_interval", t, 2000);
      while (busy && t < 10000) begin @(negedge clk); t++; end
      chk("auto_done", busy, 0);
      chk("auto_gen_count", gen_count, m_gen);
      chk("auto_drained", exp_q.size(), 0);
    end
    bus.cmd_valid = 1'b1; bus.cmd_code = CMD_RUN;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    seen = 0;
    repeat (2500) begin @(negedge clk); if (busy) seen++; end
    chk("auto_stopped", seen, 0);
    chk("auto_stopped_gen", gen_count, m_gen);
`endif

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
